addsub_seq: RTL
===============

# addsub_seq

Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes and status flags. It is the successor to the 4-bit combinational ripple adder/subtractor. Operand width is generic, and it processes CHUNK bits per clock to bound the carry path. It sits in the ALU datapath between the operand register stage and the result/flag writeback.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; N = WIDTH/CHUNK cycles per operation.

- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand set present.
- in_ready  output  1  unit can accept an operand set (high only in IDLE).
- sub  input  1  0 = a+b, 1 = a−b; sampled with a, b.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- out_valid  output  1  result and flags valid (DONE state).
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- co  output  1  carry out of MSB; for sub, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  s == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch a, b^{WIDTH{sub}}, carry=sub, and chunk index k=0; go to RUN.
- RUN: each cycle, s[k*CHUNK +: CHUNK] = a_chunk + b_chunk + carry, and carry takes the chunk carry-out.
  - On the last chunk (k=N−1), capture the carry into the MSB. Set co = final carry, ovf = carry_into_MSB ^ co, zero = (final s == 0). Go to DONE.
- DONE: out_valid=1; s, co, ovf, zero are held stable.
  - On out_ready, go to IDLE, deassert out_valid, and hold s/flags at their last values.
- Arithmetic is modulo 2^WIDTH; s wraps silently unless the saturation feature is compiled in.
- in_valid is ignored outside IDLE; operands are not re-sampled during RUN or DONE.
- N=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle.

## Timing
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; k=0.
  - out_valid=0, s=0, co=0, ovf=0, zero=0.
  - in_ready=1 from the first edge after reset.
- Reset mid-RUN or in DONE aborts the operation; the partial result is discarded and no out_valid pulse occurs.
- Latency: acceptance at edge E0 → out_valid high after edge E0+N.
- Minimum issue interval: N+2 cycles (RUN×N, DONE×1, IDLE×1) when out_ready is held high.
- Backpressure: out_valid stays high indefinitely while out_ready=0; outputs do not change.
- A simultaneous out_ready in DONE and in_valid is not accepted that cycle; in_ready rises the next cycle.
- in_ready and out_valid are decoded from registered state only; neither depends combinationally on in_valid or out_ready.

## Configuration
- ADDSUB_SEQ_SAT_EN:
  - Defined: on signed overflow, s is clamped to the signed limit. That is 2^(WIDTH−1)−1 when the true result is positive (a_MSB=0), else −2^(WIDTH−1). ovf still reports 1; co is unaffected. zero reflects the clamped s.
  - Undefined: s wraps modulo 2^WIDTH, and there is no clamping logic.

## Test plan
- WIDTH=16, CHUNK=4. Reset, then a=6, b=4, sub=0 → out_valid exactly 4 cycles after acceptance; s=10, co=0, ovf=0, zero=0.
- a=10, b=4, sub=1 → s=6, co=1, ovf=0.
- a=5, b=7, sub=1 → s=0xFFFE, co=0, ovf=0. Then a=5, b=5, sub=1 → s=0, zero=1, co=1.
- a=0x7FFF, b=1, sub=0:
  - Without macro: s=0x8000, ovf=1.
  - With ADDSUB_SEQ_SAT_EN: s=0x7FFF, ovf=1.
  - Also a=0x8000, b=1, sub=1 with macro → s=0x8000, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE → s and flags are constant, in_ready=0, and a new in_valid is ignored. Release out_ready → IDLE next cycle, and the next operation is accepted.
- Assert rst_n=0 for one edge at RUN k=2 → out_valid, s, and flags are all 0. in_ready=1 next cycle, and no result is ever presented for the aborted operation.

Source files
------------

// File: rtl/addsub_seq_if.sv
// addsub_seq_if: operand/result handshake bundle for the sequential adder/subtractor
interface addsub_seq_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;
    modport master (
        output in_valid, sub, a, b, out_ready,
        input  in_ready, out_valid, s, co, ovf, zero
    );
    modport slave (
        input  in_valid, sub, a, b, out_ready,
        output in_ready, out_valid, s, co, ovf, zero
    );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/sub, CHUNK bits per clock; define ADDSUB_SEQ_SAT_EN for signed saturation
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic         clk,
    input logic         rst_n,
    addsub_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_next;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, b_r, s_r, s_cat, s_fin;
    logic [CHUNK:0]   chunk_sum;
    logic             carry, co_r, ovf_r, zero_r, last, msb_cin, fin_ovf;
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    // next state and handshake outputs, decoded from registered state only
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        state_next    = (state == IDLE) ? (bus.in_valid ? RUN : IDLE) :
                        (state == RUN)  ? (last ? DONE : RUN) :
                                          (bus.out_ready ? IDLE : DONE);
    end
    // one chunk of the ripple, plus the overflow/clamp resolution used on the last chunk
    always_comb begin
        last      = (k == KW'(N - 1));
        chunk_sum = {1'b0, a_r[k*CHUNK +: CHUNK]} + {1'b0, b_r[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
        s_cat     = s_r;
        s_cat[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        msb_cin   = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ s_cat[WIDTH-1];
        fin_ovf   = msb_cin ^ chunk_sum[CHUNK];
`ifdef ADDSUB_SEQ_SAT_EN
        s_fin     = !fin_ovf ? s_cat :
                    a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
        s_fin     = s_cat;
`endif
    end
    // operand capture, chunk accumulation and flag writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k      <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            co_r   <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            k     <= '0;
        end else if (state == RUN) begin
            carry <= chunk_sum[CHUNK];
            k     <= last ? '0 : k + 1'b1;
            s_r   <= last ? s_fin : s_cat;
            if (last) begin
                co_r   <= chunk_sum[CHUNK];
                ovf_r  <= fin_ovf;
                zero_r <= (s_fin == '0);
            end
        end
    end
    assign bus.s    = s_r;
    assign bus.co   = co_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
endmodule
